// File: rtl/scmp_bus_pak.sv
// Shared types and constants for the SC/MP bus target: FSM states, status flag
// positions, bus widths and the backing-store command payload.
package scmp_bus_pak;

   localparam int unsigned BT_ADDR_W     = 16;
   localparam int unsigned BT_PIN_ADDR_W = 12;
   localparam int unsigned BT_DATA_W     = 8;
   localparam int unsigned BT_FLAG_W     = 4;
   localparam int unsigned BT_WAIT_W     = 4;
   localparam int unsigned BT_WAIT_MAX   = 15;

   // Position of each status flag in lat_flags / bus_d_i[7:4]
   localparam int unsigned BT_FLAG_H = 3;
   localparam int unsigned BT_FLAG_D = 2;
   localparam int unsigned BT_FLAG_I = 1;
   localparam int unsigned BT_FLAG_R = 0;

   typedef enum logic [2:0] {
      BT_IDLE,
      BT_ADDR,
      BT_SKIP,
      BT_RD_REQ,
      BT_WR_REQ,
      BT_WAIT,
      BT_RD_DRV,
      BT_WR_END
   } BT_STATE_t;

   typedef struct packed {
      logic                 we;
      logic [BT_ADDR_W-1:0] addr;
      logic [BT_DATA_W-1:0] wdata;
   } bt_mem_cmd_t;

endpackage

// File: rtl/scmp_bus_target_if.sv
// Core pin bundle plus synchronous backing-store port seen by one bus target.
interface scmp_bus_target_if;
   import scmp_bus_pak::*;

   logic [BT_PIN_ADDR_W-1:0] bus_addr;
   logic [BT_DATA_W-1:0]     bus_d_i;
   logic [BT_DATA_W-1:0]     bus_d_o;
   logic                     bus_d_oe;
   logic                     ADS_n;
   logic                     RD_n;
   logic                     WR_n;
   logic                     hold;
   logic                     mem_req;
   logic                     mem_we;
   logic [BT_ADDR_W-1:0]     mem_addr;
   logic [BT_DATA_W-1:0]     mem_wdata;
   logic [BT_DATA_W-1:0]     mem_rdata;
   logic                     mem_ack;

   modport slave (
      input  bus_addr, bus_d_i, ADS_n, RD_n, WR_n, mem_rdata, mem_ack,
      output bus_d_o, bus_d_oe, hold, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output bus_addr, bus_d_i, ADS_n, RD_n, WR_n, mem_rdata, mem_ack,
      input  bus_d_o, bus_d_oe, hold, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/scmp_wait_ctr.sv
// Wait-state counter: loads a count, decrements once per cycle, and raises a
// registered done flag once the count has been used up.
module scmp_wait_ctr
   import scmp_bus_pak::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [BT_WAIT_W-1:0] load_val,
   input  logic                 dec,
   output logic                 done
);

   logic [BT_WAIT_W-1:0] cnt_q;

   // done tracks "count is zero" so the caller sees it on the same edge the count lands there
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         done  <= 1'b0;
      end else if (load) begin
         cnt_q <= load_val;
         done  <= (load_val == '0);
      end else if (dec && !done) begin
         cnt_q <= cnt_q - BT_WAIT_W'(1);
         done  <= (cnt_q == BT_WAIT_W'(1));
      end
   end

endmodule

// File: rtl/scmp_bus_target.sv
// SC/MP external-bus responder: latches address/flags at ADS_n, turns selected
// read/write cycles into req/ack store accesses and stretches the cycle with hold.
module scmp_bus_target
   import scmp_bus_pak::*;
#(
   parameter logic [BT_ADDR_W-1:0] SEL_BASE    = 16'h0000,
   parameter logic [BT_ADDR_W-1:0] SEL_MASK    = 16'h0000,
   parameter int unsigned          WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   scmp_bus_target_if.slave      bus,
   output logic [BT_ADDR_W-1:0]  lat_addr,
   output logic [BT_FLAG_W-1:0]  lat_flags,
   output logic                  halt,
   output logic                  err
);

   if (WAIT_STATES > BT_WAIT_MAX) begin : g_bad_wait
      $error("scmp_bus_target: WAIT_STATES must be 0..15");
   end

   localparam bit HAS_WAIT = (WAIT_STATES != 0);
   localparam logic [BT_WAIT_W-1:0] WAIT_LOAD =
      BT_WAIT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   BT_STATE_t state_q, state_nx;

   logic [BT_DATA_W-1:0] d_o_q, d_o_nx;
   logic                 oe_q, oe_nx;
   logic                 hold_q, hold_nx;
   logic                 req_q, req_nx;
   bt_mem_cmd_t          cmd_q, cmd_nx;
   logic [BT_ADDR_W-1:0] lat_addr_q, lat_addr_nx;
   logic [BT_FLAG_W-1:0] lat_flags_q, lat_flags_nx;
   logic                 halt_q, halt_nx;
   logic                 err_q, err_nx;

   logic                 cnt_load, cnt_dec, cnt_done;

   logic [BT_ADDR_W-1:0] pin_addr;
   logic                 sel, rd_only, wr_only, rd_wr;

   assign pin_addr = {bus.bus_d_i[BT_FLAG_W-1:0], bus.bus_addr};
   assign sel      = ((pin_addr & SEL_MASK) == SEL_BASE);
   assign rd_only  = !bus.RD_n &&  bus.WR_n;
   assign wr_only  =  bus.RD_n && !bus.WR_n;
   assign rd_wr    = !bus.RD_n && !bus.WR_n;

   scmp_wait_ctr u_wait_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .done     (cnt_done)
   );

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BT_IDLE;
         d_o_q       <= '0;
         oe_q        <= 1'b0;
         hold_q      <= 1'b0;
         req_q       <= 1'b0;
         cmd_q       <= '0;
         lat_addr_q  <= '0;
         lat_flags_q <= '0;
         halt_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_nx;
         d_o_q       <= d_o_nx;
         oe_q        <= oe_nx;
         hold_q      <= hold_nx;
         req_q       <= req_nx;
         cmd_q       <= cmd_nx;
         lat_addr_q  <= lat_addr_nx;
         lat_flags_q <= lat_flags_nx;
         halt_q      <= halt_nx;
         err_q       <= err_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         BT_IDLE:   if (!bus.ADS_n) state_nx = sel ? BT_ADDR : BT_SKIP;
         BT_ADDR: begin
            if (rd_only)      state_nx = BT_RD_REQ;
            else if (wr_only) state_nx = BT_WR_REQ;
            else if (rd_wr)   state_nx = BT_SKIP;
         end
         BT_RD_REQ: if (bus.mem_ack) state_nx = HAS_WAIT ? BT_WAIT : BT_RD_DRV;
         BT_WR_REQ: if (bus.mem_ack) state_nx = HAS_WAIT ? BT_WAIT : BT_WR_END;
         BT_WAIT:   if (cnt_done) state_nx = cmd_q.we ? BT_WR_END : BT_RD_DRV;
         BT_RD_DRV: if (bus.RD_n) state_nx = BT_IDLE;
         BT_WR_END: if (bus.WR_n) state_nx = BT_IDLE;
         BT_SKIP:   if (bus.RD_n && bus.WR_n) state_nx = BT_IDLE;
         default:   state_nx = BT_IDLE;
      endcase
   end

   // Output logic: next values for the output registers
   always_comb begin
      d_o_nx       = d_o_q;
      oe_nx        = oe_q;
      hold_nx      = hold_q;
      req_nx       = req_q;
      cmd_nx       = cmd_q;
      lat_addr_nx  = lat_addr_q;
      lat_flags_nx = lat_flags_q;
      halt_nx      = 1'b0;
      err_nx       = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;

      // A new address strobe is only legal between cycles
      if (!bus.ADS_n && (state_q != BT_IDLE)) err_nx = 1'b1;

      case (state_q)
         BT_IDLE: begin
            if (!bus.ADS_n) begin
               lat_addr_nx  = pin_addr;
               lat_flags_nx = bus.bus_d_i[BT_DATA_W-1:BT_FLAG_W];
               halt_nx      = sel && bus.bus_d_i[BT_FLAG_W + BT_FLAG_H];
            end
         end
         BT_ADDR: begin
            if (rd_only || wr_only) begin
               req_nx       = 1'b1;
               hold_nx      = 1'b1;
               cmd_nx.we    = wr_only;
               cmd_nx.addr  = lat_addr_q;
               if (wr_only) cmd_nx.wdata = bus.bus_d_i;
            end else if (rd_wr) begin
               err_nx = 1'b1;
            end
         end
         BT_RD_REQ, BT_WR_REQ: begin
            if (bus.mem_ack) begin
               req_nx = 1'b0;
               if (state_q == BT_RD_REQ) d_o_nx = bus.mem_rdata;
               if (HAS_WAIT) begin
                  cnt_load = 1'b1;
               end else begin
                  hold_nx = 1'b0;
                  oe_nx   = (state_q == BT_RD_REQ);
               end
            end
         end
         BT_WAIT: begin
            if (cnt_done) begin
               hold_nx = 1'b0;
               oe_nx   = !cmd_q.we;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         BT_RD_DRV: if (bus.RD_n) oe_nx = 1'b0;
         default: ;
      endcase
   end

   assign bus.bus_d_o   = d_o_q;
   assign bus.bus_d_oe  = oe_q;
   assign bus.hold      = hold_q;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = cmd_q.we;
   assign bus.mem_addr  = cmd_q.addr;
   assign bus.mem_wdata = cmd_q.wdata;
   assign lat_addr      = lat_addr_q;
   assign lat_flags     = lat_flags_q;
   assign halt          = halt_q;
   assign err           = err_q;

endmodule

// File: doc/scmp_bus_target.md
# scmp_bus_target

Memory-mapped bus responder for the SC/MP core's external bus. It decodes the core's ADS_n/RD_n/WR_n strobes and latches the 16-bit address and cycle status flags at the address strobe. It converts selected read/write cycles into a req/ack transaction on a synchronous backing-store port, and stretches the bus cycle with `hold` until data is ready. It sits between the core's pins and a RAM/ROM/peripheral model, one instance per decoded region.

## Interface
Parameters:
- SEL_BASE, 16'h0000, region base; cycle selected when (addr16 & SEL_MASK) == SEL_BASE
- SEL_MASK, 16'h0000, decode mask; default selects every address
- WAIT_STATES, 0, extra cycles (0..15) inserted after mem_ack before data is valid/write completes

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- bus_addr  in  12  core address pins
- bus_d_i  in  8  core data-out pins; {H,D,I,R,addr[15:12]} during ADS_n low, write data during WR_n low
- ADS_n, RD_n, WR_n  in  1 each  core strobes, active-low
- bus_d_o  out  8  read data to core
- bus_d_oe  out  1  read data drive enable
- hold  out  1  bus-cycle stretch request to core, active-high
- mem_req, mem_we  out  1 each  backing-store request / write select
- mem_addr  out  16  backing-store address
- mem_wdata  out  8  backing-store write data
- mem_rdata  in  8  backing-store read data, valid with mem_ack
- mem_ack  in  1  backing-store completion, one-cycle pulse
- lat_addr  out  16  last latched address
- lat_flags  out  4  last latched {H,D,I,R}
- halt  out  1  one-cycle pulse when a selected cycle latches H=1
- err  out  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, ADDR, SKIP, RD_REQ, WR_REQ, WAIT, RD_DRV, WR_END.
- IDLE: on sampled ADS_n=0:
  - Latch lat_addr = {bus_d_i[3:0], bus_addr} and lat_flags = bus_d_i[7:4].
  - Go to ADDR if selected, else SKIP.
  - Pulse halt if selected and H=1.
- ADDR, RD_n=0 & WR_n=1: go to RD_REQ; mem_req=1, mem_we=0, mem_addr=lat_addr, hold=1.
- ADDR, WR_n=0 & RD_n=1: capture mem_wdata = bus_d_i on that edge; go to WR_REQ; mem_req=1, mem_we=1, hold=1.
- ADDR, RD_n=0 & WR_n=0: pulse err; go to SKIP; no memory access.
- RD_REQ / WR_REQ: hold mem_req until mem_ack is sampled.
  - On ack, drop mem_req that edge.
  - RD_REQ also latches mem_rdata into bus_d_o.
  - Then go to WAIT if WAIT_STATES>0, else RD_DRV / WR_END.
- WAIT: count WAIT_STATES cycles, then go to RD_DRV / WR_END.
- RD_DRV: bus_d_oe=1, hold=0; stay until RD_n=1, then bus_d_oe=0 and go to IDLE.
- WR_END: hold=0; go to IDLE when WR_n=1.
- SKIP: no outputs driven; go to IDLE when RD_n=1 and WR_n=1.
- ADS_n=0 sampled in any state other than IDLE: pulse err and ignore it; lat_* are unchanged.
- mem_ack outside RD_REQ/WR_REQ: ignored.

## Timing
- All outputs are registered. Reset value of every output is 0 (bus_d_o, bus_d_oe, hold, mem_*, lat_*, halt, err); state resets to IDLE.
- Address latch: 1 edge after ADS_n low.
- mem_req rises on the edge sampling RD_n/WR_n low. Earliest mem_ack is the following edge.
- Read latency, strobe-sample to bus_d_oe: 2 + WAIT_STATES cycles with zero-wait ack.
- hold is high from the request edge until the edge entering RD_DRV/WR_END.
- Reset mid-transaction: mem_req drops asynchronously and bus_d_oe releases. The backing store must tolerate an abandoned request.
- WAIT counter is 4 bits; WAIT_STATES>15 is a parameter error (elaboration assertion).

## Structure
- Shared package scmp_bus_pak: state enum BT_STATE_t, flag indices BT_FLAG_H/D/I/R (3..0), width constants.
- One sub-module, scmp_wait_ctr: 4-bit load/decrement counter with `done` flag, used by the WAIT state.
- Decode compare stays inline.

## Test plan
- Read: SEL_MASK=16'hF000, SEL_BASE=16'h1000; ADS with bus_d_i=8'h01, bus_addr=12'h234; RD_n low; ack next cycle with rdata 8'hA5 -> lat_addr 16'h1234, lat_flags 0, mem_we 0, bus_d_o 8'hA5 with oe 2 cycles after RD_n sample, hold high exactly 2 cycles.
- Write with WAIT_STATES=3: bus_d_i 8'h5A at WR_n low, ack after 2 cycles -> mem_we 1, mem_wdata 8'h5A, hold high 2+1+3 cycles.
- Unselected cycle, address 16'h2000 -> SKIP; mem_req, hold and oe stay 0.
- Halt: ADS with bus_d_i=8'h81 -> halt pulses once, lat_flags 4'b1000.
- Violations: ADS_n during RD_REQ -> err pulse, lat_addr unchanged; RD_n and WR_n low together -> err, no mem_req.
- Reset asserted in RD_REQ -> all outputs 0 immediately; the next ADS cycle completes normally.
